// File: rtl/period_sched_pkg.sv
// Shared types and constants for the period scheduler.
// Table entries hold DEF_MIN_W-bit minutes, so MIN_W must not exceed DEF_MIN_W.
package period_sched_pkg;

  localparam int DAY_MINUTES = 1440;
  localparam int DEF_MIN_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    IN_CLASS,
    DAY_DONE
  } state_t;

  typedef struct packed {
    logic [DEF_MIN_W-1:0] start_min;
    logic [DEF_MIN_W-1:0] end_min;
    logic                 valid;
  } period_entry_t;

endpackage

// File: rtl/period_scheduler_if.sv
// Configuration bus for writing the period table.
// The master drives the write strobe and entry fields; the slave reports rejected writes.
interface period_scheduler_if #(
  parameter int NUM_PERIODS = 8,
  parameter int MIN_W       = 11
);
  localparam int IDX_W = $clog2(NUM_PERIODS);

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [MIN_W-1:0] cfg_start;
  logic [MIN_W-1:0] cfg_end;
  logic             cfg_valid;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_idx, cfg_start, cfg_end, cfg_valid,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_start, cfg_end, cfg_valid,
    output cfg_err
  );

endinterface

// File: rtl/period_table.sv
// Period start/end register file with write-legality check and valid-index lookups.
// Writes are only accepted while the scheduler says the table is idle and start < end.
module period_table
  import period_sched_pkg::*;
#(
  parameter int NUM_PERIODS = 8,
  parameter int MIN_W       = DEF_MIN_W,
  localparam int IDX_W      = $clog2(NUM_PERIODS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             allow,
  period_scheduler_if.slave cfg,
  input  logic [IDX_W-1:0] query_idx,
  output logic [MIN_W-1:0] cur_start,
  output logic [MIN_W-1:0] cur_end,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_found,
  output logic [IDX_W-1:0] next_idx,
  output logic             next_found
);

  period_entry_t entries [NUM_PERIODS];
  logic          write_ok;

  assign write_ok = allow && (cfg.cfg_start < cfg.cfg_end) &&
                    (int'(cfg.cfg_idx) < NUM_PERIODS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PERIODS; i++) begin
        entries[i] <= '0;
      end
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= 1'b0;
      if (cfg.cfg_we) begin
        if (write_ok) begin
          entries[cfg.cfg_idx] <= '{start_min: DEF_MIN_W'(cfg.cfg_start),
                                    end_min:   DEF_MIN_W'(cfg.cfg_end),
                                    valid:     cfg.cfg_valid};
        end else begin
          cfg.cfg_err <= 1'b1;
        end
      end
    end
  end

  assign cur_start = MIN_W'(entries[query_idx].start_min);
  assign cur_end   = MIN_W'(entries[query_idx].end_min);

  // Scanning downward lets the lowest matching index win.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_PERIODS - 1; i >= 0; i--) begin
      if (entries[i].valid) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
        if (i > int'(query_idx)) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/period_scheduler.sv
// Walks the period table against the live minute count and emits boundary pulses.
// Optional advance warning is built only when PERIOD_SCHED_WARN_EN is defined.
module period_scheduler
  import period_sched_pkg::*;
#(
  parameter int NUM_PERIODS = 8,
  parameter int MIN_W       = DEF_MIN_W,
  parameter int WARN_MIN    = 5,
  localparam int IDX_W      = $clog2(NUM_PERIODS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIN_W-1:0] min_in,
  input  logic             day_rst,
  period_scheduler_if.slave cfg,
  output logic [IDX_W-1:0] period_idx,
  output logic             in_class,
  output logic             period_start,
  output logic             period_end,
  output logic             day_done,
  output logic             warn_pulse
);

  state_t           state;
  logic             day_rst_q;
  logic             edge_taken;
  logic [MIN_W-1:0] cur_start;
  logic [MIN_W-1:0] cur_end;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] next_idx;
  logic             first_found;
  logic             next_found;

  period_table #(
    .NUM_PERIODS (NUM_PERIODS),
    .MIN_W       (MIN_W)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .allow       ((state == IDLE) || (state == DAY_DONE)),
    .cfg         (cfg),
    .query_idx   (period_idx),
    .cur_start   (cur_start),
    .cur_end     (cur_end),
    .first_idx   (first_idx),
    .first_found (first_found),
    .next_idx    (next_idx),
    .next_found  (next_found)
  );

  // A new day is ignored only when idle with nothing to schedule.
  assign edge_taken = day_rst && !day_rst_q && ((state != IDLE) || first_found);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      period_idx   <= '0;
      in_class     <= 1'b0;
      period_start <= 1'b0;
      period_end   <= 1'b0;
      day_done     <= 1'b0;
      day_rst_q    <= 1'b0;
    end else begin
      day_rst_q    <= day_rst;
      period_start <= 1'b0;
      period_end   <= 1'b0;
      if (edge_taken) begin
        if (state == IN_CLASS) begin
          period_end <= 1'b1;
        end
        in_class <= 1'b0;
        day_done <= 1'b0;
        if (first_found) begin
          state      <= WAIT_START;
          period_idx <= first_idx;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          WAIT_START: begin
            if (min_in >= cur_start) begin
              state        <= IN_CLASS;
              period_start <= 1'b1;
              in_class     <= 1'b1;
            end
          end
          IN_CLASS: begin
            if (min_in >= cur_end) begin
              period_end <= 1'b1;
              in_class   <= 1'b0;
              if (next_found) begin
                state      <= WAIT_START;
                period_idx <= next_idx;
              end else begin
                state    <= DAY_DONE;
                day_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PERIOD_SCHED_WARN_EN
  localparam int SUM_W = MIN_W + 1;

  logic             warned;
  logic [SUM_W-1:0] warn_sum;

  // One extra bit keeps late-evening sums from wrapping.
  assign warn_sum = {1'b0, min_in} + SUM_W'(WARN_MIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warn_pulse <= 1'b0;
      warned     <= 1'b0;
    end else begin
      warn_pulse <= 1'b0;
      if (edge_taken || ((state == IN_CLASS) && (min_in >= cur_end))) begin
        warned <= 1'b0;
      end else if ((state == WAIT_START) && !warned &&
                   (warn_sum >= {1'b0, cur_start})) begin
        warn_pulse <= 1'b1;
        warned     <= 1'b1;
      end
    end
  end
`else
  assign warn_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_period_scheduler.sv
// Self-checking bench for period_scheduler: directed vector table, then random traffic
// compared against a behavioural model of the period rules.
module tb_period_scheduler;

  localparam int NP = 8;
  localparam int MW = 11;
  localparam int IW = 3;
  localparam int WM = 5;
`ifdef PERIOD_SCHED_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_CLASS = 2;
  localparam int P_DONE  = 3;

  typedef struct {
    bit rst_n;
    bit day_rst;
    int min;
    bit we;
    int idx;
    int st;
    int en;
    bit vld;
  } stim_t;

  typedef struct {
    int idx;
    bit in_class;
    bit ps;
    bit pe;
    bit done;
    bit err;
    bit warn;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
    string tag;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          day_rst;
  logic [MW-1:0] min_in;
  logic [IW-1:0] period_idx;
  logic          in_class;
  logic          period_start;
  logic          period_end;
  logic          day_done;
  logic          warn_pulse;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  // Reference model state
  int m_phase;
  int m_idx;
  bit m_dq;
  bit m_warned;
  int m_st[NP];
  int m_en[NP];
  bit m_v[NP];
  resp_t m_out;

  always #5 clk = ~clk;

  period_scheduler_if #(.NUM_PERIODS(NP), .MIN_W(MW)) cfg_bus ();

  period_scheduler #(
    .NUM_PERIODS (NP),
    .MIN_W       (MW),
    .WARN_MIN    (WM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .min_in       (min_in),
    .day_rst      (day_rst),
    .cfg          (cfg_bus),
    .period_idx   (period_idx),
    .in_class     (in_class),
    .period_start (period_start),
    .period_end   (period_end),
    .day_done     (day_done),
    .warn_pulse   (warn_pulse)
  );

  function automatic stim_t S(bit r, bit dr, int m, bit we = 0, int i = 0,
                              int st = 0, int en = 0, bit v = 0);
    stim_t s;
    s = '{rst_n: r, day_rst: dr, min: m, we: we, idx: i, st: st, en: en, vld: v};
    return s;
  endfunction

  function automatic resp_t R(int idx, bit ic, bit ps, bit pe, bit dd,
                              bit err = 0, bit wn = 0);
    resp_t r;
    r = '{idx: idx, in_class: ic, ps: ps, pe: pe, done: dd, err: err, warn: wn};
    return r;
  endfunction

  function automatic void addV(string tag, stim_t s, resp_t r);
    vecs.push_back('{s: s, r: r, tag: tag});
  endfunction

  function automatic void buildVectors();
    // Single period (10,20) swept through a day
    addV("reset0", S(0, 0, 0), R(0, 0, 0, 0, 0));
    addV("reset1", S(0, 0, 0), R(0, 0, 0, 0, 0));
    addV("wr_e0", S(1, 0, 0, 1, 0, 10, 20, 1), R(0, 0, 0, 0, 0));
    addV("day_edgeA", S(1, 1, 0), R(0, 0, 0, 0, 0));
    for (int m = 0; m <= 30; m++)
      addV($sformatf("sweepA m=%0d", m), S(1, 1, m),
           R(0, (m >= 10 && m < 20), (m == 10), (m == 20), (m >= 20), 0,
             WARN_ON && (m == 5)));
    // Illegal write rejected, legal write accepted in DAY_DONE
    addV("wr_bad_e1", S(1, 1, 30, 1, 1, 30, 25, 1), R(0, 0, 0, 0, 1, 1));
    addV("wr_e2", S(1, 1, 30, 1, 2, 20, 40, 1), R(0, 0, 0, 0, 1, 0));
    addV("day_low", S(1, 0, 0), R(0, 0, 0, 0, 1));
    addV("day_edgeB", S(1, 1, 0), R(0, 0, 0, 0, 0));
    for (int m = 0; m < 20; m++)
      addV($sformatf("sweepB m=%0d", m), S(1, 0, m),
           R(0, (m >= 10), (m == 10), 0, 0, 0, WARN_ON && (m == 5)));
    addV("b2b_end", S(1, 0, 20), R(2, 0, 0, 1, 0));
    addV("b2b_start", S(1, 0, 20), R(2, 1, 1, 0, 0, 0, WARN_ON));
    for (int m = 21; m < 40; m++) begin
      if (m == 25)
        addV("wr_in_class", S(1, 0, m, 1, 3, 41, 42, 1), R(2, 1, 0, 0, 0, 1));
      else
        addV($sformatf("sweepB m=%0d", m), S(1, 0, m), R(2, 1, 0, 0, 0));
    end
    addV("e2_end", S(1, 0, 40), R(2, 0, 0, 1, 1));
    addV("e3_absent41", S(1, 0, 41), R(2, 0, 0, 0, 1));
    addV("e3_absent42", S(1, 0, 42), R(2, 0, 0, 0, 1));
    // Day reset in the middle of a period
    addV("day_edgeC", S(1, 1, 0), R(0, 0, 0, 0, 0));
    for (int m = 0; m < 15; m++)
      addV($sformatf("sweepC m=%0d", m), S(1, 0, m),
           R(0, (m >= 10), (m == 10), 0, 0, 0, WARN_ON && (m == 5)));
    addV("edge_in_class", S(1, 1, 15), R(0, 0, 0, 1, 0));
    addV("restart", S(1, 1, 16), R(0, 1, 1, 0, 0, 0, WARN_ON));
    addV("still_class", S(1, 1, 17), R(0, 1, 0, 0, 0));
    // Synchronous reset mid-period wipes the table
    addV("rst_mid", S(0, 1, 17), R(0, 0, 0, 0, 0));
    addV("post_rst", S(1, 0, 17), R(0, 0, 0, 0, 0));
    addV("edge_empty", S(1, 1, 18), R(0, 0, 0, 0, 0));
    for (int m = 19; m <= 22; m++)
      addV($sformatf("empty m=%0d", m), S(1, 1, m), R(0, 0, 0, 0, 0));
  endfunction

  function automatic int lowestValidFrom(int from);
    for (int i = from; i < NP; i++)
      if (m_v[i]) return i;
    return -1;
  endfunction

  function automatic void modelStep(stim_t s);
    int first;
    int nxt;
    bit do_write;
    bit take_edge;
    if (!s.rst_n) begin
      m_phase = P_IDLE;
      m_idx = 0;
      m_dq = 0;
      m_warned = 0;
      for (int i = 0; i < NP; i++) m_v[i] = 0;
      m_out = R(0, 0, 0, 0, 0);
      return;
    end
    m_out.ps = 0;
    m_out.pe = 0;
    m_out.warn = 0;
    do_write = s.we && (m_phase == P_IDLE || m_phase == P_DONE) && (s.st < s.en);
    m_out.err = s.we && !do_write;
    first = lowestValidFrom(0);
    take_edge = s.day_rst && !m_dq && !(m_phase == P_IDLE && first < 0);
    m_dq = s.day_rst;
    if (take_edge) begin
      if (m_phase == P_CLASS) m_out.pe = 1;
      m_out.in_class = 0;
      m_out.done = 0;
      if (first >= 0) begin
        m_phase = P_WAIT;
        m_idx = first;
        m_warned = 0;
      end else begin
        m_phase = P_IDLE;
      end
    end else if (m_phase == P_WAIT) begin
      if (WARN_ON && !m_warned && (s.min + WM >= m_st[m_idx])) begin
        m_out.warn = 1;
        m_warned = 1;
      end
      if (s.min >= m_st[m_idx]) begin
        m_phase = P_CLASS;
        m_out.ps = 1;
        m_out.in_class = 1;
      end
    end else if (m_phase == P_CLASS && s.min >= m_en[m_idx]) begin
      m_out.pe = 1;
      m_out.in_class = 0;
      nxt = lowestValidFrom(m_idx + 1);
      if (nxt >= 0) begin
        m_phase = P_WAIT;
        m_idx = nxt;
        m_warned = 0;
      end else begin
        m_phase = P_DONE;
        m_out.done = 1;
      end
    end
    if (do_write) begin
      m_st[s.idx] = s.st;
      m_en[s.idx] = s.en;
      m_v[s.idx] = s.vld;
    end
    m_out.idx = m_idx;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst_n             = s.rst_n;
    day_rst           = s.day_rst;
    min_in            = MW'(s.min);
    cfg_bus.cfg_we    = s.we;
    cfg_bus.cfg_idx   = IW'(s.idx);
    cfg_bus.cfg_start = MW'(s.st);
    cfg_bus.cfg_end   = MW'(s.en);
    cfg_bus.cfg_valid = s.vld;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input resp_t e);
    logic [IW+5:0] act;
    logic [IW+5:0] expv;
    act  = {period_idx, in_class, period_start, period_end, day_done,
            cfg_bus.cfg_err, warn_pulse};
    expv = {IW'(e.idx), e.in_class, e.ps, e.pe, e.done, e.err, e.warn};
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got idx=%0d ic=%b ps=%b pe=%b done=%b err=%b warn=%b, want idx=%0d ic=%b ps=%b pe=%b done=%b err=%b warn=%b",
               tag, period_idx, in_class, period_start, period_end, day_done,
               cfg_bus.cfg_err, warn_pulse, e.idx, e.in_class, e.ps, e.pe,
               e.done, e.err, e.warn);
    end
  endtask

  initial begin
    stim_t s;
    int cur_min;
    bit cur_dr;
    rst_n = 1'b0;
    day_rst = 1'b0;
    min_in = '0;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_idx = '0;
    cfg_bus.cfg_start = '0;
    cfg_bus.cfg_end = '0;
    cfg_bus.cfg_valid = 1'b0;

    buildVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i].tag, vecs[i].r);
    end

    // Random traffic against the model, starting from reset
    cur_min = 0;
    cur_dr = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55) cur_min = (cur_min < 1439) ? cur_min + 1 : cur_min;
      else if (r >= 92) cur_min = int'($urandom_range(0, 150));
      if ($urandom_range(0, 39) == 0) cur_dr = !cur_dr;
      s = S((i != 0) && ($urandom_range(0, 299) != 0), cur_dr, cur_min);
      if ($urandom_range(0, 5) == 0) begin
        s.we = 1;
        s.idx = int'($urandom_range(0, NP - 1));
        s.st = int'($urandom_range(0, 120));
        s.en = int'($urandom_range(0, 120));
        s.vld = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(s);
      modelStep(s);
      checkOutput($sformatf("rand%0d", i), m_out);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
